// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency mult/multu/div/divu plus mthi/mtlo.
// Define MDU_MADD_EN to enable madd (md_op 4) and msub (md_op 5); otherwise those codes are no-ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic        rd_hi,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_block,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rdata
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] rhi, rlo;
    logic        op_legal;
    logic        op_div;
    logic        accept;
    logic        finish;
    logic [63:0] result;

    // Full 64-bit product; the low 64 bits of the extended operands' product are exact.
    function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic signed [63:0] ae, be;
        ae = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        be = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    // Returns {remainder, quotient}, with the divide-by-zero and signed-overflow corner cases pinned.
    function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always_comb begin
        op_legal = 1'b0;
        case (md_op)
            3'd0, 3'd1, 3'd2, 3'd3: op_legal = 1'b1;
`ifdef MDU_MADD_EN
            3'd4, 3'd5:             op_legal = 1'b1;
`endif
            default:                op_legal = 1'b0;
        endcase
    end

    assign op_div = (md_op == 3'd2) || (md_op == 3'd3);
    assign accept = (state == IDLE) && start && !req && op_legal;
    assign finish = (state == RUN) && (cnt <= 4'd1);

    always_comb begin
        result = 64'h0;
        case (md_op)
            3'd0:    result = mul_res(A, B, 1'b1);
            3'd1:    result = mul_res(A, B, 1'b0);
            3'd2:    result = div_res(A, B, 1'b1);
            3'd3:    result = div_res(A, B, 1'b0);
`ifdef MDU_MADD_EN
            3'd4:    result = {HI, LO} + mul_res(A, B, 1'b1);
            3'd5:    result = {HI, LO} - mul_res(A, B, 1'b1);
`endif
            default: result = 64'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = op_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (finish) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An accepted start takes priority over a same-cycle mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rhi <= 32'h0;
            rlo <= 32'h0;
            HI  <= 32'h0;
            LO  <= 32'h0;
        end else begin
            if (accept) begin
                rhi <= result[63:32];
                rlo <= result[31:0];
            end
            if (finish) begin
                HI <= rhi;
                LO <= rlo;
            end else if (state == IDLE && !accept && !req) begin
                if (we_hi) HI <= A;
                if (we_lo) LO <= A;
            end
        end
    end

    assign busy     = (state == RUN);
    assign md_block = start | busy;
    assign rdata    = rd_hi ? HI : LO;

endmodule
